// File: rtl/snake_body_tracker.sv
// -----------------------------------------------------------------------------
// snake_body_tracker
//
// Keeps the snake's body trail between the movement stage and the pixel
// printer. Each move strobe shifts the new head coordinate into a segment
// history. The module grows the body on request and scans the body for a
// head self-collision. It also produces a registered per-pixel "body here"
// flag that the colour stage ORs with the head and food prints.
//
// Ports
//   clk          divided pixel clock
//   rst          asynchronous reset, active-high
//   post_ticket  one-cycle move strobe; head_x/head_y are valid with it
//   head_x/y     new head column/row (cell units)
//   grow         one-cycle pulse: lengthen the body by one on the next shift
//   c_pixel      current scan column (cell units)
//   r_pixel      current scan row (cell units)
//   body_prnt    pixel lies on body segment 1..length-1 (1 clk latency)
//   length       active segment count, head included
//   self_hit     sticky head/body collision flag
//   busy         high while a shift or collision scan is in progress
// -----------------------------------------------------------------------------
module snake_body_tracker #(
  parameter int MAX_LEN  = 32,
  parameter int INIT_LEN = 3,
  parameter int COORD_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       post_ticket,
  input  logic [COORD_W-1:0]         head_x,
  input  logic [COORD_W-1:0]         head_y,
  input  logic                       grow,
  input  logic [COORD_W-1:0]         c_pixel,
  input  logic [COORD_W-1:0]         r_pixel,
  output logic                       body_prnt,
  output logic [$clog2(MAX_LEN):0]   length,
  output logic                       self_hit,
  output logic                       busy
);

  localparam int LEN_W = $clog2(MAX_LEN) + 1;
  localparam int IDX_W = $clog2(MAX_LEN);

  localparam logic [LEN_W-1:0]   MAX_LEN_L  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]   INIT_LEN_L = LEN_W'(INIT_LEN);
  localparam logic [LEN_W-1:0]   LEN_ONE    = LEN_W'(1);
  localparam logic [IDX_W-1:0]   IDX_ONE    = IDX_W'(1);
  localparam logic [COORD_W-1:0] SENTINEL   = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SCAN  = 2'd2,
    HIT   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [COORD_W-1:0] seg_x_q [MAX_LEN];
  logic [COORD_W-1:0] seg_y_q [MAX_LEN];
  logic [COORD_W-1:0] cap_x_q, cap_y_q;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               grow_pend_q, grow_pend_d;
  logic               self_hit_q, self_hit_d;
  logic               body_prnt_q, body_prnt_d;
  logic               capture;
  logic               do_shift;
  logic [MAX_LEN-1:0] seg_live;

  // A slot still holding the all-ones reset sentinel is off-grid: it has never
  // received a head, so it must neither print nor collide.
  always_comb begin
    seg_live = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      seg_live[i] = !((seg_x_q[i] == SENTINEL) && (seg_y_q[i] == SENTINEL));
    end
  end

  // Next-state and control decode.
  // NOTE: every signal written here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    self_hit_d = self_hit_q;
    capture    = 1'b0;
    do_shift   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (post_ticket) begin
          capture = 1'b1;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        do_shift = 1'b1;
        if (grow_pend_q && (len_q < MAX_LEN_L)) begin
          len_d = len_q + LEN_ONE;
        end
        idx_d   = IDX_ONE;
        state_d = SCAN;
      end

      SCAN: begin
        if (seg_live[idx_q] &&
            (seg_x_q[idx_q] == seg_x_q[0]) &&
            (seg_y_q[idx_q] == seg_y_q[0])) begin
          self_hit_d = 1'b1;
          state_d    = HIT;
        end else if ({1'b0, idx_q} == (len_q - LEN_ONE)) begin
          state_d = IDLE;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end

      HIT: begin
        // Terminal until reset: segments and length stay frozen.
      end

      default: state_d = IDLE;
    endcase
  end

  // A grow arriving during the SHIFT cycle is kept for the following move;
  // the shift only consumes the request that was already pending.
  assign grow_pend_d = grow | (grow_pend_q & ~do_shift);

  // Registered pixel hit over the active body (head slot 0 excluded).
  always_comb begin
    body_prnt_d = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((LEN_W'(i) < len_q) && seg_live[i] &&
          (seg_x_q[i] == c_pixel) && (seg_y_q[i] == r_pixel)) begin
        body_prnt_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, which is what makes the shift chain work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= INIT_LEN_L;
      idx_q       <= IDX_ONE;
      grow_pend_q <= 1'b0;
      self_hit_q  <= 1'b0;
      body_prnt_q <= 1'b0;
      cap_x_q     <= '0;
      cap_y_q     <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      grow_pend_q <= grow_pend_d;
      self_hit_q  <= self_hit_d;
      body_prnt_q <= body_prnt_d;
      if (capture) begin
        cap_x_q <= head_x;
        cap_y_q <= head_y;
      end
    end
  end

  // Segment history.
  // NOTE: this storage is reset on purpose; the sentinel fill is what marks
  // never-written slots as off-grid, so it cannot be left to power-up values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= SENTINEL;
        seg_y_q[i] <= SENTINEL;
      end
    end else if (do_shift) begin
      seg_x_q[0] <= cap_x_q;
      seg_y_q[0] <= cap_y_q;
      for (int i = 1; i < MAX_LEN; i++) begin
        seg_x_q[i] <= seg_x_q[i-1];
        seg_y_q[i] <= seg_y_q[i-1];
      end
    end
  end

  assign body_prnt = body_prnt_q;
  assign length    = len_q;
  assign self_hit  = self_hit_q;
  assign busy      = (state_q == SHIFT) || (state_q == SCAN);

endmodule

// File: tb/tb_snake_body_tracker.sv
// -----------------------------------------------------------------------------
// tb_snake_body_tracker
//
// Directed stimulus pushes hand-computed expectations, each tagged with the
// clock cycle at which it is due. A monitor process, clocked on the falling
// edge, pops and compares every entry that has come due.
// -----------------------------------------------------------------------------
module tb_snake_body_tracker;

  localparam int COORD_W = 8;
  localparam int LEN_W   = 6;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               post_ticket = 1'b0;
  logic               grow = 1'b0;
  logic [COORD_W-1:0] head_x = '0;
  logic [COORD_W-1:0] head_y = '0;
  logic [COORD_W-1:0] c_pixel = '0;
  logic [COORD_W-1:0] r_pixel = '0;
  logic               body_prnt;
  logic [LEN_W-1:0]   length;
  logic               self_hit;
  logic               busy;

  snake_body_tracker #(
    .MAX_LEN (32),
    .INIT_LEN(3),
    .COORD_W (COORD_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .post_ticket(post_ticket),
    .head_x     (head_x),
    .head_y     (head_y),
    .grow       (grow),
    .c_pixel    (c_pixel),
    .r_pixel    (r_pixel),
    .body_prnt  (body_prnt),
    .length     (length),
    .self_hit   (self_hit),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {S_BODY, S_LEN, S_SELF, S_BUSY} sig_e;
  typedef struct {
    int    cyc;
    sig_e  sig;
    int    val;
    string name;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Monitor: compare every expectation that is due this cycle.
  int mon_i;
  int mon_act;
  always @(negedge clk) begin
    mon_i = 0;
    while (mon_i < sb.size()) begin
      if (sb[mon_i].cyc <= cyc) begin
        case (sb[mon_i].sig)
          S_BODY:  mon_act = int'(body_prnt);
          S_LEN:   mon_act = int'(length);
          S_SELF:  mon_act = int'(self_hit);
          default: mon_act = int'(busy);
        endcase
        checks++;
        if ((sb[mon_i].cyc != cyc) || (mon_act != sb[mon_i].val)) begin
          failures++;
          $display("FAIL %s: cycle %0d (due %0d) actual=%0d required=%0d",
                   sb[mon_i].name, cyc, sb[mon_i].cyc, mon_act, sb[mon_i].val);
        end
        sb.delete(mon_i);
      end else begin
        mon_i++;
      end
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int dc, input sig_e s, input int v, input string n);
    exp_t e;
    e.cyc  = cyc + dc;
    e.sig  = s;
    e.val  = v;
    e.name = n;
    sb.push_back(e);
  endtask

  task automatic tick(input int x, input int y, input logic g);
    post_ticket = 1'b1;
    head_x      = COORD_W'(x);
    head_y      = COORD_W'(y);
    grow        = g;
    step();
    post_ticket = 1'b0;
    grow        = 1'b0;
  endtask

  task automatic wait_idle(input string n);
    int budget;
    budget = 0;
    while (busy && (budget < 200)) begin
      step();
      budget++;
    end
    checks++;
    if (busy) begin
      failures++;
      $display("FAIL %s: busy still high after %0d cycles, required idle", n, budget);
    end
  endtask

  task automatic query(input int x, input int y, input int exp_v, input string n);
    c_pixel = COORD_W'(x);
    r_pixel = COORD_W'(y);
    expect_at(1, S_BODY, exp_v, n);
    step();
  endtask

  // Asserts reset between clock edges and expects reset values at once.
  task automatic do_reset(input string tag);
    step();
    rst = 1'b1;
    expect_at(0, S_LEN,  3, {tag, "_len"});
    expect_at(0, S_SELF, 0, {tag, "_self_hit"});
    expect_at(0, S_BUSY, 0, {tag, "_busy"});
    expect_at(0, S_BODY, 0, {tag, "_body"});
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  // --------------------------------------------------------------- stimulus
  initial begin
    step();
    do_reset("por");
    query(255, 255, 0, "por_sentinel_pixel");

    // T2: trail
    tick(10, 5, 1'b0);
    expect_at(0, S_BUSY, 1, "t2_busy_shift");
    expect_at(2, S_BUSY, 1, "t2_busy_last_scan");
    expect_at(3, S_BUSY, 0, "t2_busy_done");
    wait_idle("t2_w1");
    tick(11, 5, 1'b0); wait_idle("t2_w2");
    tick(12, 5, 1'b0); wait_idle("t2_w3");
    query(11, 5, 1, "t2_seg1");
    query(12, 5, 0, "t2_head_excluded");
    query(10, 5, 1, "t2_seg2");
    query(9, 5, 0, "t2_not_body");

    // T3: grow while idle, grow with tick, saturation
    grow = 1'b1; step(); grow = 1'b0;
    tick(13, 5, 1'b0); wait_idle("t3_w1");
    expect_at(0, S_LEN, 4, "t3_len_idle_grow");
    query(10, 5, 1, "t3_seg3_now_active");
    tick(14, 5, 1'b1); wait_idle("t3_w2");
    expect_at(0, S_LEN, 5, "t3_len_coincident_grow");
    for (int i = 0; i < 32; i++) begin
      tick(15 + i, 5, 1'b1);
      wait_idle("t3_wsat");
      expect_at(0, S_LEN, (6 + i > 32) ? 32 : 6 + i, $sformatf("t3_len_pair%0d", i));
    end
    expect_at(0, S_SELF, 0, "t3_no_self_hit");
    query(15, 5, 1, "t3_last_slot");
    query(14, 5, 0, "t3_dropped_off_end");
    query(46, 5, 0, "t3_head_excluded");
    query(45, 5, 1, "t3_seg1");

    // T1: reset mid-run while the pixel sits on the body
    query(20, 5, 1, "t1_pre_reset_body");
    do_reset("t1");
    query(255, 255, 0, "t1_sentinel_pixel");
    query(20, 5, 0, "t1_history_cleared");

    // T4: collision
    tick(20, 20, 1'b1); wait_idle("t4_w1");
    tick(21, 20, 1'b1); wait_idle("t4_w2");
    expect_at(0, S_LEN, 5, "t4_len5");
    tick(21, 21, 1'b0); wait_idle("t4_w3");
    tick(20, 21, 1'b0); wait_idle("t4_w4");
    expect_at(0, S_SELF, 0, "t4_no_hit_yet");
    tick(20, 20, 1'b0);
    expect_at(4, S_BUSY, 1, "t4_busy_scanning");
    expect_at(4, S_SELF, 0, "t4_hit_not_early");
    expect_at(5, S_SELF, 1, "t4_self_hit");
    expect_at(5, S_BUSY, 0, "t4_busy_after_hit");
    wait_idle("t4_w5");
    tick(30, 30, 1'b1);
    expect_at(0, S_BUSY, 0, "t4_hit_ignores_tick");
    expect_at(1, S_BUSY, 0, "t4_hit_ignores_tick2");
    step(); step();
    expect_at(0, S_LEN, 5, "t4_len_frozen");
    expect_at(0, S_SELF, 1, "t4_self_hit_sticky");
    query(20, 21, 1, "t4_seg1_frozen");
    query(21, 20, 1, "t4_seg3_frozen");
    query(30, 30, 0, "t4_ignored_head");

    // T5: busy drop (reset also clears self_hit from HIT)
    do_reset("t5");
    for (int i = 0; i < 7; i++) begin
      tick(40 + i, 40, 1'b1);
      wait_idle("t5_wgrow");
    end
    expect_at(0, S_LEN, 10, "t5_len10");
    tick(50, 40, 1'b0);
    expect_at(0,  S_BUSY, 1, "t5_busy_start");
    expect_at(9,  S_BUSY, 1, "t5_busy_last_scan");
    expect_at(10, S_BUSY, 0, "t5_busy_low_10clk");
    step();
    tick(60, 60, 1'b0);
    wait_idle("t5_w1");
    expect_at(1, S_BUSY, 0, "t5_drop_not_queued");
    step(); step();
    tick(51, 40, 1'b0); wait_idle("t5_w2");
    query(50, 40, 1, "t5_seg0_was_first_head");
    query(60, 60, 0, "t5_dropped_head_absent");
    query(40, 40, 1, "t5_seg8");
    expect_at(0, S_LEN, 10, "t5_len_unchanged");

    // T6: async reset mid-scan
    c_pixel = 8'd50;
    r_pixel = 8'd40;
    tick(52, 40, 1'b0);
    expect_at(0, S_BODY, 1, "t6_body_before_reset");
    expect_at(1, S_BUSY, 1, "t6_busy_before_reset");
    step();
    do_reset("t6");
    expect_at(0, S_BUSY, 0, "t6_idle_after_release");
    tick(5, 5, 1'b0);
    expect_at(0, S_BUSY, 1, "t6_accepts_tick");
    expect_at(3, S_BUSY, 0, "t6_scan_len3");
    wait_idle("t6_w1");
    step();
    query(52, 40, 0, "t6_history_cleared");

    // Drain the scoreboard.
    for (int i = 0; i < 20 && sb.size() > 0; i++) step();
    while (sb.size() > 0) begin
      failures++;
      $display("FAIL %s: never compared, required=%0d", sb[0].name, sb[0].val);
      void'(sb.pop_front());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
